// File: rtl/inv_shift_sub_stage_pkg.sv
// Shared AES definitions for the inverse-cipher InvShiftRows/InvSubBytes stage.
//
// Contents:
//   STATE_W / WORD_W   - state and column widths
//   state_e            - stage FSM encoding
//   INV_SBOX           - FIPS-197 inverse S-box table
//   state_byte_idx()   - byte index of s[r,c] (r + 4c)
//   byte_msb()         - bit position of the MSB of s[r,c] in a 128-bit state
//   inv_shift_rows()   - InvShiftRows as pure wiring

package inv_shift_sub_stage_pkg;

   localparam int unsigned STATE_W = 128;
   localparam int unsigned WORD_W  = 32;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Byte index of s[r,c]; byte 0 is the most significant byte of the state.
   function automatic int unsigned state_byte_idx(input int unsigned r, input int unsigned c);
      return r + 4 * c;
   endfunction

   function automatic int unsigned byte_msb(input int unsigned r, input int unsigned c);
      return STATE_W - 1 - 8 * state_byte_idx(r, c);
   endfunction

   // sh[r, (c + r) mod 4] = s[r, c]
   function automatic logic [STATE_W-1:0] inv_shift_rows(input logic [STATE_W-1:0] s);
      logic [STATE_W-1:0] sh;
      sh = '0;
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 4; c++) begin
            sh[byte_msb(r, (c + r) % 4) -: 8] = s[byte_msb(r, c) -: 8];
         end
      end
      return sh;
   endfunction

endpackage

// File: rtl/inv_sbox.sv
// Byte inverse S-box (FIPS-197), purely combinational table lookup.
//
// Ports:
//   byte_i  8-bit input byte
//   byte_o  8-bit inverse S-box image

module inv_sbox
   import inv_shift_sub_stage_pkg::*;
(
   input  logic [7:0] byte_i,
   output logic [7:0] byte_o
);

   assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/inv_shift_sub_stage_inv_sub_word.sv
// 32-bit word inverse substitution: four byte inverse S-boxes side by side.
//
// Ports:
//   word_i  32-bit column (s[0,c] in the MSB)
//   word_o  32-bit column with every byte inverse-substituted

module inv_sub_word (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   for (genvar b = 0; b < 4; b++) begin : gen_byte
      inv_sbox u_inv_sbox (
         .byte_i (word_i[31-8*b -: 8]),
         .byte_o (word_o[31-8*b -: 8])
      );
   end

endmodule

// File: rtl/inv_shift_sub_stage.sv
// InvShiftRows + InvSubBytes stage of the AES decryption round.
//
// A state is captured (already row-shifted) into st_q, then COLS_PER_CYCLE columns per cycle
// are pushed through shared inverse S-box word lanes until all four columns are done. The
// completed state is held on out_data until the downstream accepts it; acceptance and the next
// capture may share an edge.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input state available
//   in_ready   stage can accept a state (follows out_ready while a result is waiting)
//   in_data    128-bit input state, FIPS-197 byte order
//   out_valid  completed state available (registered)
//   out_ready  downstream accepts out_data
//   out_data   InvSubBytes(InvShiftRows(in_data)) (registered)

module inv_shift_sub_stage
   import inv_shift_sub_stage_pkg::*;
#(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_data
);

   if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : gen_bad_cfg
      $error("inv_shift_sub_stage: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // For COLS_PER_CYCLE=4 the step truncates to 0, so col stays at 0 and the
   // single busy cycle is also the last one.
   localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LastCol = 2'(4 - COLS_PER_CYCLE);

   state_e             state_q, state_d;
   logic [1:0]         col_q, col_d;
   logic [STATE_W-1:0] st_q, st_d;

   logic [WORD_W-1:0]  lane_in  [COLS_PER_CYCLE];
   logic [WORD_W-1:0]  lane_out [COLS_PER_CYCLE];

   // Lane g works on column col_q + g.
   always_comb begin
      for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
         lane_in[g] = '0;
         for (int k = 0; k < 4; k++) begin
            if (col_q + 2'(g) == 2'(k)) begin
               lane_in[g] = st_q[STATE_W-1-WORD_W*k -: WORD_W];
            end
         end
      end
   end

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gen_lane
      inv_sub_word u_inv_sub_word (
         .word_i (lane_in[g]),
         .word_o (lane_out[g])
      );
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      st_d     = st_q;
      in_ready = 1'b0;

      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               st_d    = inv_shift_rows(in_data);
               col_d   = '0;
               state_d = StBusy;
            end
         end

         StBusy: begin
            for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
               for (int k = 0; k < 4; k++) begin
                  if (col_q + 2'(g) == 2'(k)) begin
                     st_d[STATE_W-1-WORD_W*k -: WORD_W] = lane_out[g];
                  end
               end
            end
            // Wraps to 0 exactly when the last group is written.
            col_d = col_q + ColStep;
            if (col_q == LastCol) begin
               state_d = StDone;
            end
         end

         StDone: begin
            // A new state can only enter once the held result leaves.
            in_ready = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  st_d    = inv_shift_rows(in_data);
                  col_d   = '0;
                  state_d = StBusy;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         col_q   <= '0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         st_q    <= st_d;
      end
   end

   assign out_valid = (state_q == StDone);
   assign out_data  = st_q;

endmodule

// File: tb/tb_inv_shift_sub_stage.sv
// Bench for inv_shift_sub_stage: three instances (COLS_PER_CYCLE = 1, 2, 4) driven by tasks,
// a scoreboard queue filled on every input handshake and drained by a monitor on every
// output handshake. The reference inverse S-box is derived arithmetically (inverse affine
// map followed by GF(2^8) inversion).

module tb_inv_shift_sub_stage;

   localparam int NDUT = 3;

   logic         clk;
   logic         rst;
   logic         in_valid  [NDUT];
   logic         in_ready  [NDUT];
   logic [127:0] in_data   [NDUT];
   logic         out_valid [NDUT];
   logic         out_ready [NDUT];
   logic [127:0] out_data  [NDUT];

   for (genvar d = 0; d < NDUT; d++) begin : g_dut
      inv_shift_sub_stage #(
         .COLS_PER_CYCLE (1 << d)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[d]),
         .in_ready  (in_ready[d]),
         .in_data   (in_data[d]),
         .out_valid (out_valid[d]),
         .out_ready (out_ready[d]),
         .out_data  (out_data[d])
      );
   end

   typedef struct {
      int           d;
      logic [127:0] data;
      int           acc;
   } exp_t;

   exp_t         sb[$];
   int           checks;
   int           failures;
   int           cyc;
   logic [7:0]   ref_tab [256];
   logic         rdy_force [NDUT];
   logic         rnd_rdy   [NDUT];
   logic         hold      [NDUT];
   logic         presented [NDUT];
   logic [127:0] hold_data [NDUT];

   localparam logic [127:0] KAT_IN  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] KAT_OUT = 128'h52f3a338_3009d79e_bf366afb_8140a5d5;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in;
      b = b_in;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] calc_inv_sbox(input logic [7:0] x);
      logic [7:0] b, y;
      b = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
      y = '0;
      for (int t = 1; t < 256; t++) begin
         if (b != 8'h00 && gmul(b, 8'(t)) == 8'h01) y = 8'(t);
      end
      return y;
   endfunction

   // Output byte (r, (c+r) mod 4) is the inverse S-box image of input byte (r, c).
   function automatic logic [127:0] model(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8] = ref_tab[s[127 - 8 * (r + 4 * c) -: 8]];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int find_first(input int d);
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].d == d) return i;
      end
      return -1;
   endfunction

   function automatic int pending(input int d);
      int n;
      n = 0;
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].d == d) n++;
      end
      return n;
   endfunction

   task automatic chk(input string name, input int d, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
      end
   endtask

   task automatic monitor_loop();
      int   idx;
      exp_t e;
      forever begin
         @(negedge clk);
         for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
               sb.delete();
               hold[d]      = 1'b0;
               presented[d] = 1'b0;
               continue;
            end
            if (hold[d]) begin
               chk("stall_valid", d, 128'(out_valid[d]), 128'(1));
               chk("stall_data", d, out_data[d], hold_data[d]);
            end
            if (out_valid[d] && !out_ready[d]) begin
               chk("stall_in_ready", d, 128'(in_ready[d]), 128'(0));
               hold[d]      = 1'b1;
               hold_data[d] = out_data[d];
            end else begin
               hold[d] = 1'b0;
            end
            if (out_valid[d] && !presented[d]) begin
               presented[d] = 1'b1;
               idx = find_first(d);
               chk("valid_has_item", d, 128'(idx >= 0), 128'(1));
               if (idx >= 0) chk("latency", d, 128'(cyc - sb[idx].acc), 128'(4 >> d));
            end
            if (out_valid[d] && out_ready[d]) begin
               idx = find_first(d);
               chk("handshake_has_item", d, 128'(idx >= 0), 128'(1));
               if (idx >= 0) begin
                  chk("data", d, out_data[d], sb[idx].data);
                  sb.delete(idx);
               end
               presented[d] = 1'b0;
            end
            if (in_valid[d] && in_ready[d]) begin
               e.d    = d;
               e.data = model(in_data[d]);
               e.acc  = cyc + 1;
               sb.push_back(e);
            end
         end
      end
   endtask

   // out_ready moves at +2 after the edge so main-sequence writes at +1 apply the same cycle.
   task automatic ready_loop();
      forever begin
         @(posedge clk);
         #2;
         for (int d = 0; d < NDUT; d++) begin
            out_ready[d] = rnd_rdy[d] ? ($urandom_range(0, 9) < 7) : rdy_force[d];
         end
      end
   endtask

   // Returns one time unit after the accepting edge; in_data is then scrambled.
   task automatic send(input int d, input logic [127:0] data);
      bit ok;
      ok          = 1'b0;
      in_valid[d] = 1'b1;
      in_data[d]  = data;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (in_ready[d]) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      in_data[d]  = rand128();
      chk("accept", d, 128'(ok), 128'(1));
   endtask

   task automatic expect_out(input int d, input logic [127:0] exp, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (out_valid[d]) begin
            ok = 1'b1;
            chk(name, d, out_data[d], exp);
         end
      end
      chk("out_valid_seen", d, 128'(ok), 128'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] a, b;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         in_valid[d]  = 1'b0;
         in_data[d]   = '0;
         out_ready[d] = 1'b1;
         rdy_force[d] = 1'b1;
         rnd_rdy[d]   = 1'b0;
         hold[d]      = 1'b0;
         presented[d] = 1'b0;
         hold_data[d] = '0;
      end
      for (int x = 0; x < 256; x++) ref_tab[x] = calc_inv_sbox(8'(x));

      fork
         monitor_loop();
         ready_loop();
         begin
            #500000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         chk("reset_out_valid", d, 128'(out_valid[d]), 128'(0));
         chk("reset_out_data", d, out_data[d], 128'(0));
         chk("reset_in_ready", d, 128'(in_ready[d]), 128'(1));
      end
      @(posedge clk);
      #1;

      // Known answers
      send(0, '0);
      expect_out(0, {16{8'h52}}, "all_zero");
      for (int d = 0; d < NDUT; d++) begin
         send(d, KAT_IN);
         expect_out(d, KAT_OUT, "kat");
      end
      send(0, {16{8'h63}});
      expect_out(0, '0, "all_63");
      send(0, {16{8'hff}});
      expect_out(0, {16{8'h7d}}, "all_ff");

      // Back-pressure, then release together with a new capture
      a = rand128();
      b = rand128();
      rdy_force[0] = 1'b0;
      send(0, a);
      expect_out(0, model(a), "stalled_result");
      repeat (10) @(posedge clk);
      #1;
      rdy_force[0] = 1'b1;
      in_valid[0]  = 1'b1;
      in_data[0]   = b;
      @(negedge clk);
      chk("same_edge", 0, 128'({in_ready[0], out_valid[0]}), 128'(2'b11));
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      expect_out(0, model(b), "after_stall");

      // Reset in the second BUSY cycle
      send(0, rand128());
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy_out_valid", 0, 128'(out_valid[0]), 128'(0));
      chk("rst_busy_out_data", 0, out_data[0], 128'(0));
      chk("rst_busy_in_ready", 0, 128'(in_ready[0]), 128'(1));
      @(posedge clk);
      #1;
      send(0, KAT_IN);
      expect_out(0, KAT_OUT, "kat_after_rst");

      // Random streams with random back-pressure
      for (int d = 0; d < NDUT; d++) begin
         rnd_rdy[d] = 1'b1;
         for (int i = 0; i < ((d == 0) ? 100 : 30); i++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
            send(d, rand128());
         end
         rnd_rdy[d] = 1'b0;
         repeat (30) @(posedge clk);
         #1;
         chk("drain", d, 128'(pending(d)), 128'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
